// File: rtl/game_input_pkg.sv
// Shared button indices and auto-repeat state encoding for the game input path.
// Also imported by player_controller.
package game_input_pkg;

    localparam int BTN_UP   = 0;
    localparam int BTN_DOWN = 1;
    localparam int BTN_FIRE = 2;
    localparam int NUM_BTNS = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HOLD_WAIT = 2'd1,
        REPEAT    = 2'd2
    } repeat_state_t;

endpackage

// File: rtl/debounce_channel.sv
// One push-button channel: two-flop synchronizer, stability counter,
// debounced level and a single-cycle pulse on each accepted rising level.
module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_meta;
    logic          sync_out;
    logic [CW-1:0] stable_cnt;

    // The counter reaching DEBOUNCE_CYCLES is the edge where the level flips,
    // so the flip is taken when the current count is one below that value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_meta  <= 1'b0;
            sync_out   <= 1'b0;
            stable_cnt <= '0;
            level      <= 1'b0;
            rise       <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync_out  <= sync_meta;
            rise      <= 1'b0;
            if (sync_out != level) begin
                if (stable_cnt == LAST) begin
                    level      <= ~level;
                    stable_cnt <= '0;
                    rise       <= ~level;
                end else begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Debounces the up/down/fire buttons and generates press pulses, with
// auto-repeat on up/down and suppression of up/down while both are held.
module button_debouncer
    import game_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] raw_btn,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_press
);

    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = $clog2(REP_MAX + 1);

    logic [NUM_BTNS-1:0] rise;
    repeat_state_t       rep_state [2];
    repeat_state_t       next_state [2];
    logic [RW-1:0]       rep_cnt [2];
    logic [RW-1:0]       next_cnt [2];
    logic [1:0]          rep_pulse;
    logic                both_dirs;

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw_btn[g]),
            .level(btn_level[g]),
            .rise (rise[g])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                rep_state[i] <= IDLE;
                rep_cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                rep_state[i] <= next_state[i];
                rep_cnt[i]   <= next_cnt[i];
            end
        end
    end

    // A count of 1 marks the last cycle of a delay/period window; the counter
    // saturates at zero outside the reload events instead of wrapping.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            next_state[i] = rep_state[i];
            next_cnt[i]   = (rep_cnt[i] != '0) ? rep_cnt[i] - 1'b1 : '0;
            rep_pulse[i]  = 1'b0;
            case (rep_state[i])
                IDLE: begin
                    if (rise[i]) begin
                        next_state[i] = HOLD_WAIT;
                        next_cnt[i]   = RW'(REPEAT_DELAY);
                        rep_pulse[i]  = 1'b1;
                    end
                end
                HOLD_WAIT, REPEAT: begin
                    if (!btn_level[i]) begin
                        next_state[i] = IDLE;
                    end else if (rep_cnt[i] == RW'(1)) begin
                        next_state[i] = REPEAT;
                        next_cnt[i]   = RW'(REPEAT_PERIOD);
                        rep_pulse[i]  = 1'b1;
                    end
                end
                default: next_state[i] = IDLE;
            endcase
        end
    end

    // Opposing directions held together cancel; the FSMs keep running so
    // dropped pulses are simply lost.
    assign both_dirs = btn_level[BTN_UP] & btn_level[BTN_DOWN];

    assign btn_press[BTN_UP]   = rep_pulse[BTN_UP] & ~both_dirs;
    assign btn_press[BTN_DOWN] = rep_pulse[BTN_DOWN] & ~both_dirs;
    assign btn_press[BTN_FIRE] = rise[BTN_FIRE];

endmodule
